lsu_ctrl: RTL and testbench

Load/store sequencer between the core's execute stage and the `main_mem` data port. It accepts one load, store or instruction-cache sync request at a time and converts byte addresses and sizes into word address, byte enables and lane-replicated write data. It stalls on the memory's ready signal and returns sign- or zero-extended load data after the SPRAM's one-cycle read latency. It also sequences `fence.i` through the memory's dirty-line flush and reports completion once the flush finishes.

---
 rtl/lsu_ctrl_pkg.sv | 44 ++++
 rtl/lsu_ctrl_align.sv | 65 ++++++
 rtl/lsu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// ============================================================================
//  lsu_ctrl_pkg
//  Shared encodings for the load/store sequencer: access sizes, FSM states
//  and the alignment check used when LSU_MISALIGN_TRAP_EN is defined.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_ctrl_pkg;

   // Access size encodings as presented on i_size
   localparam logic [1:0] LSU_SIZE_B = 2'b00;
   localparam logic [1:0] LSU_SIZE_H = 2'b01;
   localparam logic [1:0] LSU_SIZE_W = 2'b10;
   localparam logic [1:0] LSU_SIZE_R = 2'b11;

   // Sequencer states
   typedef enum logic [2:0] {
      LSU_ST_IDLE       = 3'd0,
      LSU_ST_ISSUE      = 3'd1,
      LSU_ST_RESP       = 3'd2,
      LSU_ST_FENCE      = 3'd3,
      LSU_ST_FENCE_HOLD = 3'd4,
      LSU_ST_FENCE_WAIT = 3'd5
   } lsu_state_e;

   // True when the access cannot be served as a single naturally aligned
   // word-port access; the reserved size is always treated as offending.
   function automatic logic lsu_is_misaligned(input logic [1:0] size,
                                              input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      case (size)
         LSU_SIZE_B: bad = 1'b0;
         LSU_SIZE_H: bad = a[0];
         LSU_SIZE_W: bad = (a != 2'b00);
         default:    bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_ctrl_align.sv
// ============================================================================
//  lsu_align
//  Purely combinational lane mapper: turns (size, low address bits) into byte
//  enables, replicates store data across lanes and extracts / extends the
//  addressed lane of the read data. Reserved size maps like a word and a
//  half access only looks at a[1]; offending bits are simply ignored here.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  ben_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte and halfword lanes of the read data
   always_comb begin
      w_byte = rdata_i[7:0];
      case (addr_lo_i)
         2'd0:    w_byte = rdata_i[7:0];
         2'd1:    w_byte = rdata_i[15:8];
         2'd2:    w_byte = rdata_i[23:16];
         default: w_byte = rdata_i[31:24];
      endcase
      w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Byte enables, lane-replicated store data and extended load data
   always_comb begin
      ben_o   = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = rdata_i;
      case (size_i)
         LSU_SIZE_B: begin
            ben_o   = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = unsigned_i ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         LSU_SIZE_H: begin
            ben_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = unsigned_i ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         default: begin
            ben_o   = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = rdata_i;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
//  lsu_ctrl
//  Load/store sequencer between execute and the main_mem data port. Takes one
//  load, store or fence.i at a time, stalls on memory ready, returns extended
//  load data one cycle after the read strobe and sequences the dirty-line
//  flush for fence.i.
//  Optional feature macro: LSU_MISALIGN_TRAP_EN (adds o_misaligned and turns
//  misaligned / reserved-size accesses into strobe-less completions).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int MEM_AW = 14
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   input  logic              i_fence,
   output logic              o_accept,
   output logic              o_busy,
   output logic              o_done,
   output logic [31:0]       o_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic              o_misaligned,
`endif
   output logic              o_dm_ren,
   output logic              o_dm_wen,
   output logic [3:0]        o_dm_ben,
   output logic [MEM_AW-1:0] o_dm_addr,
   output logic [31:0]       o_dm_wdata,
   input  logic [31:0]       i_dm_rdata,
   output logic              o_fence_i,
   input  logic              i_mem_ready
);

   lsu_state_e          state_q, state_d;
   logic                we_q;
   logic [1:0]          size_q;
   logic                unsigned_q;
   logic [MEM_AW+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;

   logic                w_take_req;
   logic                w_ren, w_wen, w_done, w_fence, w_accept;
   logic                w_mis;
   logic                w_load_done;
   logic [3:0]          w_ben;
   logic [31:0]         w_lane_wdata;
   logic [31:0]         w_ext_rdata;

   // Address bits above the data port are deliberately dropped
   logic                w_unused_addr_hi;
   assign w_unused_addr_hi = ^i_addr[31:MEM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_mis = lsu_is_misaligned(size_q, addr_q[1:0]);
`else
   assign w_mis = 1'b0;
`endif

   lsu_align u_align (
      .size_i     (size_q),
      .addr_lo_i  (addr_q[1:0]),
      .unsigned_i (unsigned_q),
      .wdata_i    (wdata_q),
      .rdata_i    (i_dm_rdata),
      .ben_o      (w_ben),
      .wdata_o    (w_lane_wdata),
      .rdata_o    (w_ext_rdata)
   );

   // State register and request capture; load data is kept until the next load
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= LSU_ST_IDLE;
         we_q       <= 1'b0;
         size_q     <= LSU_SIZE_B;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (w_take_req) begin
            we_q       <= i_we;
            size_q     <= i_size;
            unsigned_q <= i_unsigned;
            addr_q     <= i_addr[MEM_AW+1:0];
            wdata_q    <= i_wdata;
         end
         if (w_load_done) begin
            rdata_q <= w_ext_rdata;
         end
      end
   end

   // Next-state and strobe decode; everything is suppressed while in reset
   always_comb begin
      state_d    = state_q;
      w_take_req = 1'b0;
      w_accept   = 1'b0;
      w_ren      = 1'b0;
      w_wen      = 1'b0;
      w_done     = 1'b0;
      w_fence    = 1'b0;
      case (state_q)
         LSU_ST_IDLE: begin
            w_accept = i_fence | i_req;
            if (i_fence) begin
               state_d = LSU_ST_FENCE;
            end else if (i_req) begin
               w_take_req = 1'b1;
               state_d    = LSU_ST_ISSUE;
            end
         end
         LSU_ST_ISSUE: begin
            if (w_mis) begin
               state_d = LSU_ST_RESP;
            end else if (i_mem_ready) begin
               w_ren   = ~we_q;
               w_wen   = we_q;
               state_d = LSU_ST_RESP;
            end
         end
         LSU_ST_RESP: begin
            w_done  = 1'b1;
            state_d = LSU_ST_IDLE;
         end
         LSU_ST_FENCE: begin
            w_fence = 1'b1;
            state_d = LSU_ST_FENCE_HOLD;
         end
         LSU_ST_FENCE_HOLD: begin
            // Memory ready still reflects the pre-flush state here
            state_d = LSU_ST_FENCE_WAIT;
         end
         LSU_ST_FENCE_WAIT: begin
            if (i_mem_ready) begin
               w_done  = 1'b1;
               state_d = LSU_ST_IDLE;
            end
         end
         default: begin
            state_d = LSU_ST_IDLE;
         end
      endcase
      if (i_rst) begin
         w_take_req = 1'b0;
         w_accept   = 1'b0;
         w_ren      = 1'b0;
         w_wen      = 1'b0;
         w_done     = 1'b0;
         w_fence    = 1'b0;
      end
   end

   // Load data becomes visible in the completion cycle and is then held
   assign w_load_done = w_done && (state_q == LSU_ST_RESP) && !we_q && !w_mis;

   assign o_accept   = w_accept;
   assign o_busy     = (state_q != LSU_ST_IDLE);
   assign o_done     = w_done;
   assign o_rdata    = w_load_done ? w_ext_rdata : rdata_q;
   assign o_dm_ren   = w_ren;
   assign o_dm_wen   = w_wen;
   assign o_dm_ben   = (w_ren | w_wen) ? w_ben : 4'b0000;
   assign o_dm_addr  = (w_ren | w_wen) ? addr_q[MEM_AW+1:2] : '0;
   assign o_dm_wdata = w_wen ? w_lane_wdata : 32'h0;
   assign o_fence_i  = w_fence;

`ifdef LSU_MISALIGN_TRAP_EN
   assign o_misaligned = w_done && (state_q == LSU_ST_RESP) && w_mis;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
//  tb_lsu_ctrl
//  Directed bench for lsu_ctrl: stores, byte/half/word loads, ready stalls,
//  fence.i sequencing, misaligned handling and reset in ISSUE.
//  Honours LSU_MISALIGN_TRAP_EN when defined for the build.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

   localparam int MEM_AW = 14;

   logic              clk = 1'b0;
   logic              rst;
   logic              req, we, uns, fence, ready;
   logic [1:0]        size;
   logic [31:0]       addr, wdata, dm_rdata;
   logic              accept, busy, done, dm_ren, dm_wen, fence_i;
   logic [31:0]       rdata, dm_wdata;
   logic [3:0]        dm_ben;
   logic [MEM_AW-1:0] dm_addr;
`ifdef LSU_MISALIGN_TRAP_EN
   logic              misaligned;
`endif

   int n_err   = 0;
   int n_check = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.MEM_AW(MEM_AW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req        (req),
      .i_we         (we),
      .i_size       (size),
      .i_unsigned   (uns),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .i_fence      (fence),
      .o_accept     (accept),
      .o_busy       (busy),
      .o_done       (done),
      .o_rdata      (rdata),
`ifdef LSU_MISALIGN_TRAP_EN
      .o_misaligned (misaligned),
`endif
      .o_dm_ren     (dm_ren),
      .o_dm_wen     (dm_wen),
      .o_dm_ben     (dm_ben),
      .o_dm_addr    (dm_addr),
      .o_dm_wdata   (dm_wdata),
      .i_dm_rdata   (dm_rdata),
      .o_fence_i    (fence_i),
      .i_mem_ready  (ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_check++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are changed here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling, well away from edges
   task automatic settle();
      #3;
   endtask

   task automatic put_req(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
      addr = '0; wdata = '0; fence = 1'b0; ready = 1'b1; dm_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      settle();
      chk("rst_busy",  {31'h0, busy},    32'h0);
      chk("rst_done",  {31'h0, done},    32'h0);
      chk("rst_rdata", rdata,            32'h0);
      chk("rst_strb",  {30'h0, dm_ren, dm_wen}, 32'h0);

      // ---- sw 0x104 <- DEADBEEF ----
      tick(); put_req(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF); settle();
      chk("sw_accept", {31'h0, accept}, 32'h1);
      tick(); req = 1'b0; settle();
      chk("sw_wen",   {31'h0, dm_wen}, 32'h1);
      chk("sw_ren",   {31'h0, dm_ren}, 32'h0);
      chk("sw_addr",  {18'h0, dm_addr}, 32'h041);
      chk("sw_ben",   {28'h0, dm_ben}, 32'hF);
      chk("sw_wdata", dm_wdata, 32'hDEAD_BEEF);
      tick(); settle();
      chk("sw_done",  {31'h0, done}, 32'h1);
      tick(); settle();
      chk("sw_idle",  {30'h0, busy, done}, 32'h0);

      // ---- lb 0x103, memory word 0x80000000 ----
      dm_rdata = 32'h8000_0000;
      tick(); put_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0); settle();
      chk("lb_accept", {31'h0, accept}, 32'h1);
      tick(); req = 1'b0; settle();
      chk("lb_ren", {31'h0, dm_ren}, 32'h1);
      chk("lb_ben", {28'h0, dm_ben}, 32'h8);
      tick(); settle();
      chk("lb_done",  {31'h0, done}, 32'h1);
      chk("lb_rdata", rdata, 32'hFFFF_FF80);
      tick(); dm_rdata = 32'h0; settle();
      chk("lb_hold",  rdata, 32'hFFFF_FF80);

      // ---- lbu 0x103 ----
      dm_rdata = 32'h8000_0000;
      tick(); put_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0); settle();
      tick(); req = 1'b0; settle();
      tick(); settle();
      chk("lbu_rdata", rdata, 32'h0000_0080);

      // ---- sh 0x102 <- 1234ABCD ----
      tick(); put_req(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD); settle();
      tick(); req = 1'b0; settle();
      chk("sh_ben",   {28'h0, dm_ben}, 32'hC);
      chk("sh_wdata", dm_wdata, 32'hABCD_ABCD);
      chk("sh_addr",  {18'h0, dm_addr}, 32'h040);
      tick(); settle();
      chk("sh_done",  {31'h0, done}, 32'h1);

      // ---- lh 0x102 (signed) from 0x8001_7FFF -> upper half ----
      dm_rdata = 32'h8001_7FFF;
      tick(); put_req(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0); settle();
      tick(); req = 1'b0; settle();
      tick(); settle();
      chk("lh_rdata", rdata, 32'hFFFF_8001);

      // ---- lw 0x100 with 3-cycle ready stall ----
      dm_rdata = 32'h1357_9BDF;
      tick(); put_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0); ready = 1'b0; settle();
      tick(); req = 1'b0; settle();
      chk("stall1_strb", {30'h0, dm_ren, dm_wen}, 32'h0);
      chk("stall1_busy", {31'h0, busy}, 32'h1);
      tick(); settle();
      chk("stall2_strb", {30'h0, dm_ren, dm_wen}, 32'h0);
      tick(); settle();
      chk("stall3_strb", {30'h0, dm_ren, dm_wen}, 32'h0);
      chk("stall3_busy", {31'h0, busy}, 32'h1);
      tick(); ready = 1'b1; settle();
      chk("stall_ren",  {31'h0, dm_ren}, 32'h1);
      chk("stall_done0", {31'h0, done}, 32'h0);
      tick(); settle();
      chk("stall_done", {31'h0, done}, 32'h1);
      chk("lw_rdata",   rdata, 32'h1357_9BDF);

      // ---- fence + coincident req, ready low 4 cycles ----
      tick(); fence = 1'b1; put_req(1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0);
      ready = 1'b0; settle();
      chk("fn_accept", {31'h0, accept}, 32'h1);
      chk("fn_nostrb0", {31'h0, fence_i}, 32'h0);
      tick(); fence = 1'b0; settle();
      chk("fn_fence_i", {31'h0, fence_i}, 32'h1);
      chk("fn_noacc",   {31'h0, accept}, 32'h0);
      chk("fn_noren",   {31'h0, dm_ren}, 32'h0);
      tick(); settle();
      chk("fn_hold_done", {31'h0, done}, 32'h0);
      tick(); settle();
      chk("fn_wait3", {31'h0, done}, 32'h0);
      tick(); settle();
      chk("fn_wait4", {31'h0, done}, 32'h0);
      tick(); ready = 1'b1; settle();
      chk("fn_done", {31'h0, done}, 32'h1);
      tick(); settle();
      chk("fn_req_acc", {31'h0, accept}, 32'h1);
      tick(); req = 1'b0; settle();
      chk("fn_req_ren",  {31'h0, dm_ren}, 32'h1);
      chk("fn_req_addr", {18'h0, dm_addr}, 32'h042);
      tick(); settle();
      tick(); settle();

      // ---- fence with ready always high: HOLD ignores ready ----
      tick(); fence = 1'b1; settle();
      tick(); fence = 1'b0; settle();
      chk("ff_fence_i", {31'h0, fence_i}, 32'h1);
      tick(); settle();
      chk("ff_hold", {31'h0, done}, 32'h0);
      tick(); settle();
      chk("ff_done", {31'h0, done}, 32'h1);
      tick(); settle();
      chk("ff_idle", {31'h0, busy}, 32'h0);

      // ---- lw 0x106 (misaligned) ----
      dm_rdata = 32'hCAFE_F00D;
      tick(); put_req(1'b0, 2'b10, 1'b0, 32'h0000_0106, 32'h0); settle();
      tick(); req = 1'b0; settle();
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_nostrb", {30'h0, dm_ren, dm_wen}, 32'h0);
      tick(); settle();
      chk("mis_done",  {31'h0, done}, 32'h1);
      chk("mis_flag",  {31'h0, misaligned}, 32'h1);
      chk("mis_rdata", rdata, 32'h1357_9BDF);
`else
      chk("mis_ren",  {31'h0, dm_ren}, 32'h1);
      chk("mis_addr", {18'h0, dm_addr}, 32'h041);
      chk("mis_ben",  {28'h0, dm_ben}, 32'hF);
      tick(); settle();
      chk("mis_done",  {31'h0, done}, 32'h1);
      chk("mis_rdata", rdata, 32'hCAFE_F00D);
`endif
      tick(); settle();

      // ---- reset landing in ISSUE ----
      tick(); put_req(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h5555_AAAA); settle();
      chk("rs_accept", {31'h0, accept}, 32'h1);
      tick(); req = 1'b0; rst = 1'b1; settle();
      chk("rs_nostrb", {30'h0, dm_ren, dm_wen}, 32'h0);
      tick(); rst = 1'b0; settle();
      chk("rs_idle",  {31'h0, busy}, 32'h0);
      chk("rs_done",  {31'h0, done}, 32'h0);
      chk("rs_rdata", rdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_check);
      $finish;
   end

endmodule

`default_nettype wire
